// File: rtl/register_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port between REQ_N requesters.
// Define REGISTER_WRITE_ARBITER_INIT_EN to build the post-reset INIT sweep writing INIT_VAL to registers 1..ADDR_L-1.
module register_write_arbiter #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_L   = 32,
  parameter int                ADDR_W   = $clog2(ADDR_L),
  parameter int                REQ_N    = 2,
  parameter int                ID_W     = (REQ_N > 1) ? $clog2(REQ_N) : 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REQ_N-1:0]        req_valid,
  output logic [REQ_N-1:0]        req_ready,
  input  logic [REQ_N*ADDR_W-1:0] req_addr,
  input  logic [REQ_N*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_en,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  logic [ADDR_W-1:0] addr_arr [REQ_N];
  logic [DATA_W-1:0] data_arr [REQ_N];

  for (genvar i = 0; i < REQ_N; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              run_active;

`ifdef REGISTER_WRITE_ARBITER_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign run_active = (state_q == ST_RUN);
`else
  logic unused_init_val;

  assign run_active      = 1'b1;
  assign unused_init_val = ^INIT_VAL;
`endif

  assign busy = ~run_active;

  // Round-robin search starting at ptr_q; scan wraps modulo REQ_N.
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     scan;

  // NOTE: always_comb uses blocking assignments and gives every output a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    scan        = '0;
    if (run_active && !reset) begin
      for (int off = 0; off < REQ_N; off++) begin
        scan = {1'b0, ptr_q} + (ID_W+1)'(off);
        if (scan >= (ID_W+1)'(REQ_N)) scan = scan - (ID_W+1)'(REQ_N);
        if (!grant_found && req_valid[scan[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = scan[ID_W-1:0];
        end
      end
    end
    if (grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    grant_id_d = '0;
    ptr_d      = ptr_q;
`ifdef REGISTER_WRITE_ARBITER_INIT_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (state_q == ST_INIT) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = INIT_VAL;
      cnt_d     = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(ADDR_L - 1)) state_d = ST_RUN;
    end else
`endif
    if (grant_found) begin
      grant_id_d = grant_idx;
      ptr_d      = (grant_idx == ID_W'(REQ_N - 1)) ? '0 : grant_idx + ID_W'(1);
      // The register file forwards on address match, so a write to r0 must look idle.
      if (addr_arr[grant_idx] != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_arr[grant_idx];
        wr_data_d = data_arr[grant_idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
`ifdef REGISTER_WRITE_ARBITER_INIT_EN
      state_q    <= ST_INIT;
      cnt_q      <= ADDR_W'(1);
`endif
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
`ifdef REGISTER_WRITE_ARBITER_INIT_EN
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard bench for register_write_arbiter: a per-cycle reference model feeds expected
// outputs into a queue that a negedge monitor drains and compares.
module tb_register_write_arbiter;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_L   = 32;
  localparam int          ADDR_W   = 5;
  localparam int          REQ_N    = 2;
  localparam int          ID_W     = 1;
  localparam logic [31:0] INIT_VAL = 32'h0;
`ifdef REGISTER_WRITE_ARBITER_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [9:0]        req_addr = '0;
  logic [63:0]       req_data = '0;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic [0:0]        grant_id;
  logic              busy;

  register_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_L(ADDR_L), .ADDR_W(ADDR_W),
    .REQ_N(REQ_N), .ID_W(ID_W), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ready;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gid;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state and the inputs held during the previous cycle.
  int          m_ptr  = 0;
  bit          m_init = 1'b0;
  int          m_cnt  = 1;
  logic        p_rst  = 1'b1;
  logic [1:0]  p_valid = '0;
  logic [1:0]  p_ready = '0;
  logic [4:0]  p_addr [2] = '{5'd0, 5'd0};
  logic [31:0] p_data [2] = '{32'd0, 32'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First valid requester at or after ptr, wrapping; -1 when none.
  function automatic int arb(input logic [1:0] v, input int ptr);
    for (int off = 0; off < REQ_N; off++) begin
      int k;
      k = (ptr + off) % REQ_N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    int   k;
    @(posedge clk);
    e = '0;
    if (p_rst) begin
      m_ptr  = 0;
      m_init = INIT_EN;
      m_cnt  = 1;
    end else if (m_init) begin
      e.wr_en = 1'b1;
      e.addr  = 5'(m_cnt);
      e.data  = INIT_VAL;
      if (m_cnt == ADDR_L - 1) m_init = 1'b0;
      m_cnt++;
    end else begin
      k = arb(p_valid, m_ptr);
      if (k >= 0) begin
        e.gid = (k == 1);
        m_ptr = (k + 1) % REQ_N;
        if (p_addr[k] != 5'd0) begin
          e.wr_en = 1'b1;
          e.addr  = p_addr[k];
          e.data  = p_data[k];
        end
      end
    end
    e.busy = m_init;
    #1;
    reset     = rst;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    e.ready   = '0;
    if (!rst && !m_init) begin
      k = arb(v, m_ptr);
      if (k >= 0) e.ready[k] = 1'b1;
    end
    exp_q.push_back(e);
    p_rst     = rst;
    p_valid   = v;
    p_ready   = e.ready;
    p_addr[0] = a0;
    p_addr[1] = a1;
    p_data[0] = d0;
    p_data[1] = d1;
  endtask

  // Requesters keep valid/addr/data until a transfer, then may issue something new.
  task automatic rand_step(input bit allow_rst);
    logic [1:0]  v;
    logic [4:0]  a [2];
    logic [31:0] d [2];
    logic        rst;
    for (int i = 0; i < 2; i++) begin
      if (p_valid[i] && !p_ready[i]) begin
        v[i] = 1'b1;
        a[i] = p_addr[i];
        d[i] = p_data[i];
      end else begin
        v[i] = ($urandom_range(0, 99) < 60);
        a[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d[i] = $urandom;
      end
    end
    rst = allow_rst && ($urandom_range(0, 99) < 2);
    step(rst, v, a[0], a[1], d[0], d[1]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_ready", 32'(req_ready), 32'(e.ready));
        check("wr_en",     32'(wr_en),     32'(e.wr_en));
        check("wr_addr",   32'(wr_addr),   32'(e.addr));
        check("wr_data",   wr_data,        e.data);
        check("grant_id",  32'(grant_id),  32'(e.gid));
        check("busy",      32'(busy),      32'(e.busy));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    step(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    step(1'b1, 2'b11, 5'd3, 5'd7, 32'h11, 32'h22);
    // Sweep (when built) with both requesters waiting, then alternating grants.
    for (int i = 0; i < 36; i++) step(1'b0, 2'b11, 5'd3, 5'd7, 32'h11, 32'h22);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    // Single request from requester 0.
    step(1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    // Write to r0 from requester 1: accepted but shown as idle.
    step(1'b0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h1234);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    step(1'b0, 2'b01, 5'd4, 5'd0, 32'h44, 32'h0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    // Reset, request on the first free cycle, then reset again mid-sweep.
    step(1'b1, 2'b01, 5'd9, 5'd0, 32'hA5A50009, 32'h0);
    step(1'b0, 2'b01, 5'd9, 5'd0, 32'hA5A50009, 32'h0);
    for (int i = 0; i < 40 && m_init && m_cnt != 10; i++)
      step(1'b0, 2'b01, 5'd9, 5'd0, 32'hA5A50009, 32'h0);
    step(1'b1, 2'b01, 5'd9, 5'd0, 32'hA5A50009, 32'h0);
    for (int i = 0; i < 36; i++) step(1'b0, 2'b01, 5'd9, 5'd0, 32'hA5A50009, 32'h0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) rand_step(1'b1);
    for (int i = 0; i < 40; i++) rand_step(1'b0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
